// File: rtl/shift_pkg.sv
// Shared types for the universal shift register.
// Operation encoding and control state.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_SHR  = 3'b001,
        OP_SHL  = 3'b010,
        OP_LOAD = 3'b011,
        OP_ROR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ASR  = 3'b110,
        OP_RSV  = 3'b111
    } op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register: single-step shift/rotate/load
// plus a multi-cycle burst with busy/done handshake.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    output logic [WIDTH-1:0] out,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] AMT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_t              op_q, op_d;
    logic             done_q, done_d;

    op_t              op_in;
    logic [CNT_W-1:0] amt_cl;
    logic             op_moves;

    // One position of movement (or load/hold) for a given op.
    function automatic logic [WIDTH-1:0] next_val(
        input logic [WIDTH-1:0] v,
        input op_t              o,
        input logic [WIDTH-1:0] ld,
        input logic             s
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (o)
            OP_SHR:  r = {s, v[WIDTH-1:1]};
            OP_SHL:  r = {v[WIDTH-2:0], s};
            OP_LOAD: r = ld;
            OP_ROR:  r = {v[0], v[WIDTH-1:1]};
            OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign op_in  = op_t'(op);
    assign amt_cl = (amt > AMT_MAX) ? AMT_MAX : amt;

    // Ops that move bits and so may run as a burst.
    always_comb begin
        case (op_in)
            OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: op_moves = 1'b1;
            default:                               op_moves = 1'b0;
        endcase
    end

    // State and datapath registers; reset aborts any burst silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    // Next state: start beats en in IDLE; BURST ignores all controls.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_moves && amt_cl != '0) begin
                        state_d = ST_BURST;
                        cnt_d   = amt_cl;
                        op_d    = op_in;
                    end else if (op_moves) begin
                        done_d = 1'b1;
                    end else begin
                        out_d  = next_val(out_q, op_in, d, sin);
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    out_d = next_val(out_q, op_in, d, sin);
                end
            end
            ST_BURST: begin
                out_d = next_val(out_q, op_q, d, sin);
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are direct views of the registered state.
    always_comb begin
        out    = out_q;
        sout_r = out_q[0];
        sout_l = out_q[WIDTH-1];
        busy   = (state_q == ST_BURST);
        done   = done_q;
    end

endmodule
